// File: rtl/vram_arbiter.sv
// Arbitrates a single-port VRAM between a video fetch port and a CPU port.
// Video has priority. A CPU that has waited MAX_WAIT cycles gets the next slot.
module vram_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              CLK_50,
    input  logic              resetN,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ready,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stat_clr,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [STALL_W-1:0] STALL_SAT  = '1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    logic [WAIT_W-1:0]  wait_q,      wait_d;
    logic [STALL_W-1:0] stall_q,     stall_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic               mem_we_q,    mem_we_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    owner_e             own_s1_q,    own_s1_d;
    logic               vid_rvalid_q, vid_rvalid_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;

    logic cpu_starved_c;
    logic vid_ready_c;
    logic cpu_ack_c;
    logic cpu_stall_c;

    // Grant decision: the starved CPU preempts video for exactly one slot.
    always_comb begin
        cpu_starved_c = cpu_req && (wait_q == WAIT_LIMIT);
        vid_ready_c   = resetN && vid_req && !cpu_starved_c;
        cpu_ack_c     = resetN && cpu_req && !vid_ready_c;
        cpu_stall_c   = cpu_req && !cpu_ack_c;
    end

    // Next-state: RAM command register, owner pipeline and counters.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        own_s1_d     = OWN_NONE;
        wait_d       = '0;
        stall_d      = stall_q;

        if (vid_ready_c) begin
            mem_addr_d = vid_addr;
            own_s1_d   = OWN_VID;
        end else if (cpu_ack_c) begin
            mem_addr_d = cpu_addr;
            if (cpu_we) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = cpu_wdata;
            end else begin
                own_s1_d = OWN_CPU;
            end
        end

        if (cpu_stall_c && (wait_q != WAIT_LIMIT)) begin
            wait_d = wait_q + WAIT_W'(1);
        end else if (cpu_stall_c) begin
            wait_d = wait_q;
        end

        if (stat_clr) begin
            stall_d = '0;
        end else if (cpu_stall_c && (stall_q != STALL_SAT)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        // Second owner stage is held one-hot as the two rvalid flops.
        vid_rvalid_d = (own_s1_q == OWN_VID);
        cpu_rvalid_d = (own_s1_q == OWN_CPU);
    end

    always_ff @(posedge CLK_50) begin
        if (!resetN) begin
            wait_q       <= '0;
            stall_q      <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            own_s1_q     <= OWN_NONE;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            wait_q       <= wait_d;
            stall_q      <= stall_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            own_s1_q     <= own_s1_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    // RAM read data is steered straight to the owner in the return cycle.
    assign vid_ready  = vid_ready_c;
    assign cpu_ack    = cpu_ack_c;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_rdata  = vid_rvalid_q ? mem_rdata : '0;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_vram_arbiter;

    localparam int MAXW = 4;

    logic        CLK_50 = 1'b0;
    logic        resetN;
    logic        vid_req, cpu_req, cpu_we, stat_clr;
    logic [9:0]  vid_addr, cpu_addr;
    logic [15:0] cpu_wdata;
    logic        vid_ready, vid_rvalid, cpu_ack, cpu_rvalid, mem_we;
    logic [15:0] vid_rdata, cpu_rdata, mem_wdata, stall_cnt;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;

    logic        b_vid_ready, b_vid_rvalid, b_cpu_ack, b_cpu_rvalid, b_mem_we;
    logic [15:0] b_vid_rdata, b_cpu_rdata, b_mem_wdata, b_stall_cnt;
    logic [9:0]  b_mem_addr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 CLK_50 = ~CLK_50;

    vram_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_WAIT(MAXW)) dut (
        .CLK_50(CLK_50), .resetN(resetN),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ready(vid_ready),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_clr(stat_clr), .stall_cnt(stall_cnt)
    );

    // Long starvation limit so the stall counter can be driven to saturation.
    vram_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_WAIT(255)) dut_b (
        .CLK_50(CLK_50), .resetN(resetN),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ready(b_vid_ready),
        .vid_rvalid(b_vid_rvalid), .vid_rdata(b_vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .stat_clr(stat_clr), .stall_cnt(b_stall_cnt)
    );

    // Single-port synchronous RAM, read-old-data.
    logic [15:0] ram [0:1023];
    always @(posedge CLK_50) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: each read is a queue entry due two cycles later.
    typedef struct {
        int          due;
        int          who;
        logic [15:0] data;
    } rd_t;

    rd_t         q[$];
    logic [15:0] m_mem [0:1023];
    bit          m_valid = 0;
    int          m_wait = 0;
    int          m_stall = 0;
    bit          m_we = 0;
    logic [9:0]  m_addr = '0;
    logic [15:0] m_wdata = '0;

    always @(negedge CLK_50) begin : cmp
        bit e_vr, e_ca, e_vrv, e_crv;
        cyc++;
        if (m_valid) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            e_vrv = 0;
            e_crv = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].who == 1) begin
                    e_vrv = 1;
                    chk("vid_rdata", 32'(vid_rdata), 32'(q[0].data));
                end else begin
                    e_crv = 1;
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(q[0].data));
                end
                void'(q.pop_front());
            end
            chk("vid_rvalid", 32'(vid_rvalid), 32'(e_vrv));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
        end

        e_vr = 0;
        e_ca = 0;
        if (resetN) begin
            if (cpu_req && m_wait >= MAXW) e_ca = 1;
            else if (vid_req)              e_vr = 1;
            else if (cpu_req)              e_ca = 1;
        end
        chk("vid_ready", 32'(vid_ready), 32'(e_vr));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ca));

        if (!resetN) begin
            m_valid = 1;
            m_we = 0;
            m_addr = '0;
            m_wdata = '0;
            m_wait = 0;
            m_stall = 0;
            q.delete();
        end else begin
            m_we = 0;
            if (e_vr) begin
                m_addr = vid_addr;
                q.push_back('{cyc + 2, 1, m_mem[vid_addr]});
            end else if (e_ca) begin
                m_addr = cpu_addr;
                if (cpu_we) begin
                    m_we = 1;
                    m_wdata = cpu_wdata;
                    m_mem[cpu_addr] = cpu_wdata;
                end else begin
                    q.push_back('{cyc + 2, 2, m_mem[cpu_addr]});
                end
            end
            if (cpu_req && !e_ca) begin
                m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
                m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            end else begin
                m_wait = 0;
            end
            if (stat_clr) m_stall = 0;
        end
    end

    task automatic step();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic idle();
        vid_req = 0;
        cpu_req = 0;
        cpu_we = 0;
        stat_clr = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = init_word(i);
            m_mem[i] = init_word(i);
        end
        ram[5] = 16'h1234;
        m_mem[5] = 16'h1234;
        resetN = 0;
        idle();
        vid_addr = '0;
        cpu_addr = '0;
        cpu_wdata = '0;

        // Reset with both requests raised
        step(); vid_req = 1; cpu_req = 1; #2;
        chk("rst_vid_ready", 32'(vid_ready), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        step(); #2;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);

        // CPU read of addr 5 in the first cycle out of reset
        step(); resetN = 1; vid_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5; #2;
        chk("rd5_ack", 32'(cpu_ack), 32'd1);
        step(); cpu_req = 0; #2;
        chk("rd5_mem_addr", 32'(mem_addr), 32'd5);
        chk("rd5_rvalid_early", 32'(cpu_rvalid), 32'd0);
        step(); #2;
        chk("rd5_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd5_rdata", 32'(cpu_rdata), 32'h1234);

        // Contention for three cycles, then video drops
        for (int k = 0; k < 3; k++) begin
            step(); vid_req = 1; vid_addr = 10'(10 + k); cpu_req = 1; cpu_we = 0; cpu_addr = 10'd20; #2;
            chk("cont_vid_ready", 32'(vid_ready), 32'd1);
            chk("cont_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        step(); vid_req = 0; #2;
        chk("cont_cpu_ack4", 32'(cpu_ack), 32'd1);
        chk("cont_stall3", 32'(stall_cnt), 32'd3);
        step(); idle(); step(); step();

        // CPU write then video read of the same address
        step(); cpu_req = 1; cpu_we = 1; cpu_addr = 10'd7; cpu_wdata = 16'hBEEF; #2;
        chk("wr7_ack", 32'(cpu_ack), 32'd1);
        step(); cpu_req = 0; cpu_we = 0; vid_req = 1; vid_addr = 10'd7; #2;
        chk("wr7_vid_ready", 32'(vid_ready), 32'd1);
        chk("wr7_mem_we", 32'(mem_we), 32'd1);
        chk("wr7_mem_addr", 32'(mem_addr), 32'd7);
        chk("wr7_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        step(); vid_req = 0; #2;
        chk("wr7_we_drop", 32'(mem_we), 32'd0);
        chk("wr7_addr_hold", 32'(mem_addr), 32'd7);
        step(); #2;
        chk("wr7_vid_rvalid", 32'(vid_rvalid), 32'd1);
        chk("wr7_vid_rdata", 32'(vid_rdata), 32'hBEEF);
        chk("wr7_no_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        step();

        // Starvation: CPU wins one slot out of every five
        for (int k = 0; k < 12; k++) begin
            step(); vid_req = 1; vid_addr = 10'(100 + k); cpu_req = 1; cpu_we = 0; cpu_addr = 10'd3; #2;
            chk("starve_cpu_ack", 32'(cpu_ack), 32'((k % 5) == 4));
            chk("starve_vid_ready", 32'(vid_ready), 32'((k % 5) != 4));
        end

        // Clear wins over a concurrent stall
        step(); stat_clr = 1; #2;
        step(); stat_clr = 0; vid_req = 0; #2;
        chk("clr_stall", 32'(stall_cnt), 32'd0);
        step(); idle(); step(); step();

        // Reset one cycle after a CPU read accept drops the read
        step(); cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5; #2;
        chk("drop_ack", 32'(cpu_ack), 32'd1);
        step(); cpu_req = 0; resetN = 0; #2;
        chk("drop_mem_addr", 32'(mem_addr), 32'd5);
        chk("drop_rst_ack", 32'(cpu_ack), 32'd0);
        step(); resetN = 1; #2;
        chk("drop_mem_addr0", 32'(mem_addr), 32'd0);
        chk("drop_mem_we0", 32'(mem_we), 32'd0);
        chk("drop_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("drop_vid_rvalid", 32'(vid_rvalid), 32'd0);
        chk("drop_cpu_rdata", 32'(cpu_rdata), 32'd0);
        step(); cpu_req = 1; cpu_addr = 10'd9; #2;
        chk("post_rst_ack", 32'(cpu_ack), 32'd1);
        step(); cpu_req = 0; #2;
        step(); #2;
        chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("post_rst_rdata", 32'(cpu_rdata), 32'h5353);

        // Stall counter saturation on the long-wait instance
        step(); stat_clr = 1; vid_req = 1; vid_addr = 10'd1; cpu_req = 1; cpu_we = 0; cpu_addr = 10'd3;
        step(); stat_clr = 0;
        repeat (65900) step();
        #2;
        chk("sat_stall", 32'(b_stall_cnt), 32'hFFFF);
        repeat (20) step();
        #2;
        chk("sat_hold", 32'(b_stall_cnt), 32'hFFFF);
        step(); stat_clr = 1;
        step(); stat_clr = 0; #2;
        chk("sat_clr", 32'(b_stall_cnt), 32'd0);
        step(); idle();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, sets the VRAM word address width.
REQ-002 Parameter DATA_W, default 16, sets the VRAM word width.
REQ-003 Parameter MAX_WAIT, default 8, sets the CPU starvation limit in cycles; legal range 1..255.
REQ-004 Port CLK_50  in  1  is the single clock; all state updates on its rising edge.
REQ-005 Port resetN  in  1  is the reset: synchronous and active-low.
REQ-006 Port vid_req  in  1  carries the video fetch read request.
REQ-007 Port vid_addr  in  ADDR_W  carries the video read address.
REQ-008 Port vid_ready  out  1  accepts the video request this cycle (combinational).
REQ-009 Port vid_rvalid  out  1  marks valid video read data.
REQ-010 Port vid_rdata  out  DATA_W  carries the video read data.
REQ-011 Port cpu_req  in  1  carries the CPU access request; held stable until accepted.
REQ-012 Port cpu_we  in  1  selects the CPU operation: 1 = write, 0 = read.
REQ-013 Port cpu_addr  in  ADDR_W  carries the CPU address.
REQ-014 Port cpu_wdata  in  DATA_W  carries the CPU write data.
REQ-015 Port cpu_ack  out  1  accepts the CPU request this cycle (combinational).
REQ-016 Port cpu_rvalid  out  1  marks valid CPU read data.
REQ-017 Port cpu_rdata  out  DATA_W  carries the CPU read data.
REQ-018 Port mem_addr  out  ADDR_W  carries the registered single-port RAM address.
REQ-019 Port mem_we  out  1  is the registered RAM write enable.
REQ-020 Port mem_wdata  out  DATA_W  carries the registered RAM write data.
REQ-021 Port mem_rdata  in  DATA_W  carries RAM read data, valid 1 cycle after the mem_addr cycle.
REQ-022 Port stat_clr  in  1  clears stall_cnt synchronously.
REQ-023 Port stall_cnt  out  16  counts CPU stall cycles, saturating.

Function
REQ-024 At most one request (video or CPU) shall be accepted per cycle; back-to-back acceptance every cycle shall be supported.
REQ-025 Priority: video wins over CPU, except when wait_cnt == MAX_WAIT, where the CPU wins and vid_ready = 0.
REQ-026 vid_ready = vid_req & !(cpu_req & wait_cnt == MAX_WAIT); cpu_ack = cpu_req & !(vid_req & vid_ready).
REQ-027 wait_cnt (8 bit) shall increment on each cycle with cpu_req & !cpu_ack, saturate at MAX_WAIT, and clear on cpu_ack or !cpu_req.
REQ-028 A request accepted in cycle N shall drive mem_addr/mem_we/mem_wdata in cycle N+1; with no acceptance in N, cycle N+1 shall have mem_we = 0 and hold mem_addr.
REQ-029 A video read accepted in cycle N shall produce vid_rvalid = 1 in cycle N+2, with vid_rdata = mem_rdata in that cycle.
REQ-030 A CPU read accepted in cycle N shall produce cpu_rvalid = 1 in cycle N+2, with cpu_rdata = mem_rdata; CPU writes shall never raise cpu_rvalid.
REQ-031 Returns shall be tagged by a 2-stage owner pipeline (NONE/VID/CPU); only the owner's rvalid shall assert, and both rvalids shall never be high together.
REQ-032 rdata outputs shall be don't-care when their rvalid = 0.
REQ-033 stall_cnt shall increment on each cycle with cpu_req & !cpu_ack and saturate at 0xFFFF.
REQ-034 stat_clr shall take precedence over increment: the next value is 0.
REQ-035 A CPU write followed by a video read of the same address in the next accepted slot shall return the new data (program order at the RAM port).

Reset
REQ-036 With resetN = 0 at a clock edge, the block shall clear mem_we, mem_addr, mem_wdata, vid_rvalid, cpu_rvalid, wait_cnt, stall_cnt and the owner pipeline to 0/NONE.
REQ-037 During reset, vid_ready and cpu_ack shall be 0.
REQ-038 Reads in flight at reset shall be dropped with no rvalid afterwards.
REQ-039 The first acceptance shall be possible in the first cycle with resetN = 1.

Verification
REQ-040 Scenario: CPU read addr 5 (RAM[5] = 0x1234), no video -> cpu_ack in N, mem_addr = 5 in N+1, cpu_rvalid with 0x1234 in N+2.
REQ-041 Scenario: vid_req and cpu_req together for 3 cycles -> video accepted 3 times, stall_cnt = 3, cpu_ack in the 4th cycle.
REQ-042 Scenario: MAX_WAIT = 4, vid_req held high, cpu_req held high -> CPU stalled 4 cycles, then cpu_ack = 1 and vid_ready = 0 for exactly 1 cycle; the pattern repeats.
REQ-043 Scenario: CPU write 0xBEEF to addr 7 then video read addr 7 -> mem_we = 1 for one cycle; vid_rdata = 0xBEEF 2 cycles after the video accept.
REQ-044 Scenario: stall_cnt preloaded to 0xFFFF by stalling, with stall continuing -> stays 0xFFFF; stat_clr pulse together with a stall -> 0.
REQ-045 Scenario: resetN low one cycle after a CPU read accept -> no cpu_rvalid, all outputs 0; a new request right after reset is accepted.
